// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch front end: widths, reset
// vector, fetch FSM encoding and the debug view of the controller state.
package if_fetch_ctrl_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ILEN     = 32;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Snapshot of the controller exposed for observation only.
    typedef struct packed {
        fetch_state_e state;
        logic         kill;
    } fetch_dbg_t;

endpackage

// File: rtl/if_fetch_ctrl_pc_reg.sv
// Fetch PC register: async reset to the reset vector, loads a redirect
// target (forced word aligned) or advances by one instruction.
module fetch_pc_reg #(
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_target_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            incr_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next PC: a redirect target wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (load_target_i) begin
            pc_d = target_i & ~XLEN'(3);
        end else if (incr_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request at a time,
// a one-entry instruction buffer towards decode, and redirect handling that
// discards stale responses or buffered instructions.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, address and payload hold steady until that edge and
// ready may toggle freely. Every output comes from a register or the state.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN     = if_fetch_ctrl_pkg::XLEN,
    parameter int unsigned     ILEN     = if_fetch_ctrl_pkg::ILEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(if_fetch_ctrl_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_resp_valid_i,
    input  logic [ILEN-1:0] imem_resp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [ILEN-1:0] inst_o,
    output fetch_dbg_t      dbg_o
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic            req_valid_q;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] pc;
    logic            pc_load;
    logic            pc_incr;
    logic            req_fire;

    // req_valid_q mirrors "state is REQ" but is held low through reset.
    assign req_fire = req_valid_q && (state_q == ST_REQ) && imem_req_ready_i;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_target_i (pc_load),
        .target_i      (redirect_pc_i),
        .incr_i        (pc_incr),
        .pc_o          (pc)
    );

    // Next-state, kill flag, buffer capture and PC control.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_load   = 1'b0;
        pc_incr   = 1'b0;
        case (state_q)
            ST_REQ: begin
                pc_load = redirect_valid_i;
                if (req_fire) begin
                    state_d = ST_WAIT;
                    kill_d  = redirect_valid_i;
                end
            end
            ST_WAIT: begin
                pc_load = redirect_valid_i;
                if (imem_resp_valid_i) begin
                    if (kill_q || redirect_valid_i) begin
                        // Stale response: drop it, PC already holds the target.
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        inst_d    = imem_resp_data_i;
                        inst_pc_d = pc;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect_valid_i) begin
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    pc_load = 1'b1;
                    state_d = ST_REQ;
                end else if (inst_ready_i) begin
                    pc_incr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // FSM, kill flag, request valid and instruction buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            req_valid_q <= (state_d == ST_REQ);
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = pc;
    assign inst_valid_o     = (state_q == ST_HOLD);
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;
    assign dbg_o            = '{state: state_q, kill: kill_q};

    // A response is only legal while a request is outstanding.
    a_resp_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid_i |-> (state_q == ST_WAIT));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a bench-side memory with random latency, and a
// transaction-level model of which instructions decode must see.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [63:0] imem_req_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [63:0] inst_pc_o;
    logic [31:0] inst_o;
    fetch_dbg_t  dbg;

    if_fetch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_pc_i     (redirect_pc_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_pc_o         (inst_pc_o),
        .inst_o            (inst_o),
        .dbg_o             (dbg)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: instructions decode is owed, next fetch address
    logic [63:0] exp_pc_q[$];
    logic [31:0] exp_q[$];
    logic [63:0] exp_addr;
    bit          outstanding;
    bit          stale;

    // bench memory
    bit          mem_busy;
    int          mem_cnt;
    logic [63:0] mem_addr;
    logic [31:0] mem_data;
    int          dly_min = 1;
    int          dly_max = 1;
    bit          force_en = 1'b0;
    logic [31:0] force_data = '0;

    bit          last_accept;
    bit          last_consume;
    int          n_accept = 0;
    int          n_consume = 0;

    task automatic model_reset();
        exp_pc_q.delete();
        exp_q.delete();
        exp_addr    = RST_PC;
        outstanding = 1'b0;
        stale       = 1'b0;
        mem_busy    = 1'b0;
        mem_cnt     = 0;
    endtask

    task automatic idle_inputs();
        redirect_valid_i  = 1'b0;
        redirect_pc_i     = '0;
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = '0;
        inst_ready_i      = 1'b0;
    endtask

    // One clock cycle; called just after a falling edge.
    task automatic cycle(input bit req_rdy, input bit inst_rdy, input bit redir,
                         input logic [63:0] target);
        bit          accept;
        bit          consume;
        bit          resp;
        logic [63:0] cur_addr;
        cur_addr = exp_addr;

        n_checks++;
        if (inst_valid_o !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL inst_valid got=%b exp=%b", inst_valid_o, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            if (inst_pc_o !== exp_pc_q[0] || inst_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL inst_payload got=%h/%h exp=%h/%h", inst_pc_o, inst_o,
                         exp_pc_q[0], exp_q[0]);
            end
        end
        if (outstanding || exp_q.size() != 0) begin
            n_checks++;
            if (imem_req_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL req_busy got=%b exp=0", imem_req_valid_o);
            end
        end else if (imem_req_valid_o === 1'b1) begin
            n_checks++;
            if (imem_req_addr_o !== cur_addr) begin
                n_fail++;
                $display("FAIL req_addr got=%h exp=%h", imem_req_addr_o, cur_addr);
            end
        end

        resp = mem_busy && (mem_cnt == 0);
        imem_req_ready_i  = req_rdy;
        inst_ready_i      = inst_rdy;
        redirect_valid_i  = redir;
        redirect_pc_i     = target;
        imem_resp_valid_i = resp;
        imem_resp_data_i  = resp ? mem_data : $urandom;

        accept  = (imem_req_valid_o === 1'b1) && req_rdy;
        consume = (inst_valid_o === 1'b1) && inst_rdy;
        last_accept  = accept;
        last_consume = consume;

        if (consume && exp_q.size() != 0) begin
            void'(exp_pc_q.pop_front());
            void'(exp_q.pop_front());
            n_consume++;
        end
        if (resp) begin
            if (!stale && !redir) begin
                exp_pc_q.push_back(mem_addr);
                exp_q.push_back(mem_data);
                exp_addr = mem_addr + 64'd4;
            end
            mem_busy    = 1'b0;
            outstanding = 1'b0;
            stale       = 1'b0;
        end
        if (redir) begin
            exp_addr = target & ~64'd3;
            if (outstanding) stale = 1'b1;
            if (!consume && exp_q.size() != 0) begin
                void'(exp_pc_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
        if (accept) begin
            n_accept++;
            outstanding = 1'b1;
            stale       = redir;
            mem_busy    = 1'b1;
            mem_addr    = cur_addr;
            mem_cnt     = $urandom_range(dly_max, dly_min) - 1;
            mem_data    = force_en ? force_data : $urandom;
        end else if (mem_busy) begin
            mem_cnt--;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(input int max_cyc);
        int k;
        k = 0;
        while (imem_req_valid_o !== 1'b1 && k < max_cyc) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            k++;
        end
        n_checks++;
        if (imem_req_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_req timeout got=%b exp=1", imem_req_valid_o);
        end
    endtask

    task automatic wait_inst(input int max_cyc);
        int k;
        k = 0;
        while (inst_valid_o !== 1'b1 && k < max_cyc) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            k++;
        end
        n_checks++;
        if (inst_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_inst timeout got=%b exp=1", inst_valid_o);
        end
    endtask

    // Asynchronous reset in mid-cycle, released on a falling edge.
    task automatic reset_now();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%b/%b exp=0/0", imem_req_valid_o, inst_valid_o);
        end
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (dbg.kill !== 1'b0 || imem_req_addr_o !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_release got=%b/%h exp=0/%h", dbg.kill, imem_req_addr_o, RST_PC);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== RST_PC || inst_valid_o !== 1'b0 ||
            inst_o !== 32'd0 || inst_pc_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_values got=%b %h %b %h %h exp=0 %h 0 0 0", imem_req_valid_o,
                     imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o, RST_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (dbg.kill !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_kill got=%b exp=0", dbg.kill);
        end
    endtask

    task automatic test_throughput();
        int          acc_cyc[$];
        logic [63:0] acc_addr[$];
        dly_min = 1;
        dly_max = 1;
        for (int c = 0; c < 30; c++) begin
            logic [63:0] a;
            a = imem_req_addr_o;
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (last_accept) begin
                acc_cyc.push_back(c);
                acc_addr.push_back(a);
            end
        end
        n_checks++;
        if (acc_cyc.size() < 9) begin
            n_fail++;
            $display("FAIL tput_count got=%0d exp>=9", acc_cyc.size());
        end
        for (int i = 0; i < 3 && i < acc_addr.size(); i++) begin
            n_checks++;
            if (acc_addr[i] !== RST_PC + 64'(4 * i)) begin
                n_fail++;
                $display("FAIL tput_addr%0d got=%h exp=%h", i, acc_addr[i], RST_PC + 64'(4 * i));
            end
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL tput_gap got=%0d exp=3", acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_req_stall();
        reset_now();
        wait_req(4);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RST_PC) begin
                n_fail++;
                $display("FAIL req_stall got=%b/%h exp=1/%h", imem_req_valid_o, imem_req_addr_o, RST_PC);
            end
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (!last_accept) begin
            n_fail++;
            $display("FAIL req_accept got=0 exp=1");
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_hold_stall();
        logic [63:0] hpc;
        force_en   = 1'b1;
        force_data = 32'h0000_0013;
        wait_req(6);
        wait_inst(6);
        hpc = (exp_pc_q.size() != 0) ? exp_pc_q[0] : 64'd0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (inst_valid_o !== 1'b1 || inst_o !== 32'h13 || inst_pc_o !== hpc ||
                imem_req_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stall got=%b %h %h %b exp=1 00000013 %h 0", inst_valid_o,
                         inst_o, inst_pc_o, imem_req_valid_o, hpc);
            end
            cycle(1'b1, 1'b0, 1'b0, '0);
        end
        cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (!last_consume) begin
            n_fail++;
            $display("FAIL hold_consume got=0 exp=1");
        end
        force_en = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int seen_bad;
        int cons0;
        seen_bad   = 0;
        dly_min    = 3;
        dly_max    = 3;
        force_en   = 1'b1;
        force_data = 32'hDEAD_BEEF;
        wait_req(6);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cons0 = n_consume;
        cycle(1'b0, 1'b1, 1'b1, 64'h8000_0100);
        for (int i = 0; i < 8 && imem_req_valid_o !== 1'b1; i++) begin
            if (inst_valid_o === 1'b1) seen_bad++;
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0100) begin
            n_fail++;
            $display("FAIL redir_wait_addr got=%b/%h exp=1/0000000080000100", imem_req_valid_o,
                     imem_req_addr_o);
        end
        n_checks++;
        if (seen_bad != 0 || n_consume != cons0) begin
            n_fail++;
            $display("FAIL redir_wait_drop got=%0d exp=0", seen_bad + n_consume - cons0);
        end
        force_en = 1'b0;
        dly_min  = 1;
        dly_max  = 1;
    endtask

    task automatic test_redirect_hold();
        int cons0;
        wait_req(6);
        wait_inst(6);
        cons0 = n_consume;
        cycle(1'b0, 1'b1, 1'b1, 64'h8000_0203);
        n_checks++;
        if (n_consume != cons0 + 1) begin
            n_fail++;
            $display("FAIL redir_hold_consume got=%0d exp=%0d", n_consume, cons0 + 1);
        end
        wait_req(4);
        n_checks++;
        if (imem_req_addr_o !== 64'h8000_0200) begin
            n_fail++;
            $display("FAIL redir_hold_addr got=%h exp=0000000080000200", imem_req_addr_o);
        end
        wait_inst(6);
        cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_reset_mid();
        dly_min = 4;
        dly_max = 4;
        wait_req(6);
        cycle(1'b1, 1'b1, 1'b0, '0);
        reset_now();
        dly_min = 1;
        dly_max = 1;
        wait_req(4);
        n_checks++;
        if (imem_req_addr_o !== RST_PC || dbg.kill !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h/%b exp=%h/0", imem_req_addr_o, dbg.kill, RST_PC);
        end
        wait_inst(6);
        cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_wrap();
        wait_req(6);
        cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        n_checks++;
        if (imem_req_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_target got=%h exp=fffffffffffffffc", imem_req_addr_o);
        end
        cycle(1'b1, 1'b1, 1'b0, '0);
        wait_inst(6);
        cycle(1'b0, 1'b1, 1'b0, '0);
        wait_req(4);
        n_checks++;
        if (imem_req_addr_o !== 64'd0) begin
            n_fail++;
            $display("FAIL wrap_zero got=%h exp=0", imem_req_addr_o);
        end
    endtask

    task automatic test_back_to_back();
        dly_min = 5;
        dly_max = 5;
        wait_req(6);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 64'h0000_0000_1234_5000);
        n_checks++;
        if (dbg.kill !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_kill got=%b exp=1", dbg.kill);
        end
        cycle(1'b0, 1'b1, 1'b1, 64'h0000_0000_4000_0008);
        n_checks++;
        if (dbg.kill !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_kill2 got=%b exp=1", dbg.kill);
        end
        wait_req(8);
        n_checks++;
        if (imem_req_addr_o !== 64'h0000_0000_4000_0008) begin
            n_fail++;
            $display("FAIL b2b_addr got=%h exp=0000000040000008", imem_req_addr_o);
        end
        dly_min = 1;
        dly_max = 1;
    endtask

    task automatic test_random();
        int cons0;
        cons0   = n_consume;
        dly_min = 1;
        dly_max = 4;
        for (int i = 0; i < 2000; i++) begin
            logic [63:0] t;
            t = {$urandom, $urandom};
            cycle($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60,
                  $urandom_range(99, 0) < 8, t);
        end
        n_checks++;
        if (n_consume - cons0 < 50) begin
            n_fail++;
            $display("FAIL random_progress got=%0d exp>=50", n_consume - cons0);
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_req_stall();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
